// File: rtl/if_pc_redirect_unit_if.sv
// Fetch-stage bundle: redirect requests from ID, instruction memory port,
// and the IF/ID register outputs.
interface if_pc_redirect_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            jr_control;
  logic [XLEN-1:0] jr_target;
  logic            jump;
  logic [25:0]     jump_index;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [31:0]     if_id_instr;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic            if_id_valid;
  logic            flush;
  logic            jr_misaligned;

  modport slave (
    input  stall, jr_control, jr_target, jump, jump_index,
           branch_taken, branch_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
           flush, jr_misaligned
  );

  modport master (
    output stall, jr_control, jr_target, jump, jump_index,
           branch_taken, branch_target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
           flush, jr_misaligned
  );
endinterface

// File: rtl/if_pc_redirect_unit.sv
// Instruction-fetch stage: program counter, next-PC selection with
// JR > jump > branch priority, and the IF/ID pipeline register.
module if_pc_redirect_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = '0
) (
  input logic clk,
  input logic reset_n,
  if_pc_redirect_unit_if.slave bus
);

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_JR
  } sel_e;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc4_q;
  logic            valid_q;
  logic            misal_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  sel_e            sel;
  logic            redirect;
  logic            misal_d;

  assign pc_plus4 = pc_q + FOUR;

  // Redirect requests only count while ID holds a real instruction.
  always_comb begin
    sel    = SEL_SEQ;
    target = pc_plus4;
    if (valid_q) begin
      if (bus.jr_control)        sel = SEL_JR;
      else if (bus.jump)         sel = SEL_JUMP;
      else if (bus.branch_taken) sel = SEL_BRANCH;
    end
    case (sel)
      SEL_JR:     target = {bus.jr_target[XLEN-1:2], 2'b00};
      SEL_JUMP:   target = {pc4_q[XLEN-1:28], bus.jump_index, 2'b00};
      SEL_BRANCH: target = bus.branch_target;
      default:    target = pc_plus4;
    endcase
  end

  assign redirect = (sel != SEL_SEQ);
  assign misal_d  = (sel == SEL_JR) && (bus.jr_target[1:0] != 2'b00);

  // Redirect wins over stall: the transfer in ID is final.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      misal_q <= misal_d;
      if (redirect) begin
        pc_q    <= target;
        instr_q <= NOP_INSTR;
        pc4_q   <= '0;
        valid_q <= 1'b0;
      end else if (!bus.stall) begin
        pc_q    <= pc_plus4;
        instr_q <= bus.imem_rdata;
        pc4_q   <= pc_plus4;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.flush          = redirect;
  assign bus.jr_misaligned  = misal_q;

endmodule

// File: tb/tb_if_pc_redirect_unit.sv
// Directed bench for the fetch stage; instruction memory returns the
// address XOR a fixed tag so fetched words are recognisable.
module tb_if_pc_redirect_unit;
  localparam logic [31:0] TAG = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  if_pc_redirect_unit_if #(.XLEN(32)) bus ();

  if_pc_redirect_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.imem_rdata = bus.imem_addr ^ TAG;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic state(input string tag, input logic [31:0] addr, input logic [31:0] pc4,
                       input logic vld);
    chk({tag, "_addr"}, bus.imem_addr, addr);
    chk({tag, "_pc4"}, bus.if_id_pc_plus4, pc4);
    chk({tag, "_valid"}, {31'b0, bus.if_id_valid}, {31'b0, vld});
  endtask

  task automatic clear_req();
    bus.stall         = 1'b0;
    bus.jr_control    = 1'b0;
    bus.jump          = 1'b0;
    bus.branch_taken  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    clear_req();
    bus.jr_target     = '0;
    bus.jump_index    = '0;
    bus.branch_target = '0;

    // Reset state
    #3;
    state("rst", 32'h0, 32'h0, 1'b0);
    chk("rst_instr", bus.if_id_instr, NOP);
    chk("rst_misal", {31'b0, bus.jr_misaligned}, 32'h0);
    #9 reset_n = 1'b1;
    #1;
    state("rel", 32'h0, 32'h0, 1'b0);

    // Free-running fetch
    step(); state("seq1", 32'h4, 32'h4, 1'b1);
    chk("seq1_instr", bus.if_id_instr, TAG ^ 32'h0);
    step(); state("seq2", 32'h8, 32'h8, 1'b1);
    step(); state("seq3", 32'hC, 32'hC, 1'b1);
    step(); state("seq4", 32'h10, 32'h10, 1'b1);
    chk("seq4_instr", bus.if_id_instr, TAG ^ 32'hC);

    // Stall holds everything
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      state("stall", 32'h10, 32'h10, 1'b1);
      chk("stall_instr", bus.if_id_instr, TAG ^ 32'hC);
    end
    bus.stall = 1'b0;
    step(); state("unstall", 32'h14, 32'h14, 1'b1);
    chk("unstall_instr", bus.if_id_instr, TAG ^ 32'h10);

    // Misaligned JR
    bus.jr_control = 1'b1;
    bus.jr_target  = 32'h0000_0203;
    #1 chk("jr_flush", {31'b0, bus.flush}, 32'h1);
    step(); state("jr", 32'h200, 32'h0, 1'b0);
    chk("jr_instr", bus.if_id_instr, NOP);
    chk("jr_misal", {31'b0, bus.jr_misaligned}, 32'h1);

    // Branch during bubble is ignored
    bus.jr_control    = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_1000;
    #1 chk("bubble_flush", {31'b0, bus.flush}, 32'h0);
    step(); state("bubble", 32'h204, 32'h204, 1'b1);
    chk("bubble_misal", {31'b0, bus.jr_misaligned}, 32'h0);
    chk("bubble_instr", bus.if_id_instr, TAG ^ 32'h200);

    // Branch to set up the jump region
    bus.branch_target = 32'h4000_000C;
    step(); state("br", 32'h4000_000C, 32'h0, 1'b0);
    clear_req();
    step(); state("br_seq", 32'h4000_0010, 32'h4000_0010, 1'b1);
    chk("br_seq_instr", bus.if_id_instr, TAG ^ 32'h4000_000C);

    // Jump beats branch
    bus.jump          = 1'b1;
    bus.jump_index    = 26'h000_0040;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h1234_5678;
    #1 chk("j_flush", {31'b0, bus.flush}, 32'h1);
    step(); state("j", 32'h4000_0100, 32'h0, 1'b0);
    chk("j_misal", {31'b0, bus.jr_misaligned}, 32'h0);
    clear_req();
    step(); state("j_seq", 32'h4000_0104, 32'h4000_0104, 1'b1);

    // Jump under stall is still taken
    bus.stall      = 1'b1;
    bus.jump       = 1'b1;
    bus.jump_index = 26'h000_0080;
    #1 chk("js_flush", {31'b0, bus.flush}, 32'h1);
    step(); state("js", 32'h4000_0200, 32'h0, 1'b0);
    clear_req();
    step(); state("js_seq", 32'h4000_0204, 32'h4000_0204, 1'b1);

    // JR beats jump, aligned target gives no pulse
    bus.jr_control = 1'b1;
    bus.jr_target  = 32'h0000_0300;
    bus.jump       = 1'b1;
    step(); state("jrj", 32'h300, 32'h0, 1'b0);
    chk("jrj_misal", {31'b0, bus.jr_misaligned}, 32'h0);
    clear_req();
    step(); state("jrj_seq", 32'h304, 32'h304, 1'b1);

    // PC wrap
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hFFFF_FFF8;
    step(); state("wr_br", 32'hFFFF_FFF8, 32'h0, 1'b0);
    clear_req();
    step(); state("wr1", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    step(); state("wr2", 32'h0, 32'h0, 1'b1);
    chk("wr2_instr", bus.if_id_instr, TAG ^ 32'hFFFF_FFFC);
    step(); state("wr3", 32'h4, 32'h4, 1'b1);

    // Asynchronous reset during a redirect
    bus.jr_control = 1'b1;
    bus.jr_target  = 32'h0000_0203;
    #1 chk("ar_flush", {31'b0, bus.flush}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    state("ar", 32'h0, 32'h0, 1'b0);
    chk("ar_instr", bus.if_id_instr, NOP);
    chk("ar_misal", {31'b0, bus.jr_misaligned}, 32'h0);
    chk("ar_noflush", {31'b0, bus.flush}, 32'h0);
    step(); state("ar_hold", 32'h0, 32'h0, 1'b0);
    chk("ar_hold_misal", {31'b0, bus.jr_misaligned}, 32'h0);
    clear_req();
    reset_n = 1'b1;
    step(); state("ar_rel", 32'h4, 32'h4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/if_pc_redirect_unit.md
Name: if_pc_redirect_unit

Overview:
Instruction-fetch stage of the 5-stage pipeline. It holds the program counter and the IF/ID pipeline register. It consumes the jump-register select from the ID-stage decode, plus jump/branch resolution and the hazard-unit stall. From these it selects next-PC and flushes the wrong-path instruction.

Parameters:
XLEN, 32, datapath/PC width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, encoding injected into IF/ID on flush or reset

Ports:
clk  input  1  single system clock, rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit: hold PC and IF/ID
jr_control  input  1  ID-stage jump-register select
jr_target  input  XLEN  register-file value for JR target
jump  input  1  ID-stage direct jump
jump_index  input  26  instruction[25:0] of the jump in ID
branch_taken  input  1  ID-stage branch resolved taken
branch_target  input  XLEN  computed branch target
imem_addr  output  XLEN  instruction memory address (= PC)
imem_rdata  input  32  instruction memory read data, combinational
if_id_instr  output  32  IF/ID instruction
if_id_pc_plus4  output  XLEN  IF/ID PC+4
if_id_valid  output  1  IF/ID holds a real instruction
flush  output  1  wrong-path squash indicator, same cycle as redirect
jr_misaligned  output  1  one-cycle pulse: JR target[1:0] != 0

Behaviour:
- Reset (asynchronous, reset_n=0): pc=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc_plus4=0; if_id_valid=0; jr_misaligned=0. imem_addr follows pc. Deassertion takes effect at the next rising edge. Reset mid-redirect discards the redirect.
- imem_addr = pc, combinational. PC+4 computed modulo 2^XLEN (0xFFFF_FFFC+4 wraps to 0).
- Redirect priority, highest first: jr_control > jump > branch_taken > sequential.
  - JR: next_pc = {jr_target[XLEN-1:2],2'b00}. If jr_target[1:0] != 0, jr_misaligned=1 for exactly the next cycle (registered).
  - Jump: next_pc = {if_id_pc_plus4[31:28], jump_index, 2'b00}. Uses the PC+4 of the instruction in ID.
  - Branch: next_pc = branch_target.
- redirect = jr_control | jump | branch_taken. flush = redirect, combinational.
- Redirect cycle edge: pc <= target; if_id_instr <= NOP_INSTR; if_id_valid <= 0; if_id_pc_plus4 <= 0. The fetched wrong-path instruction is discarded. Branch penalty is 1 bubble.
- Redirect overrides stall: the redirect is taken even when stall=1. Rationale: the ID-stage control transfer is final, and stall only protects the instruction being squashed.
- Redirect inputs are qualified by if_id_valid. When if_id_valid=0, jr_control, jump and branch_taken are ignored: no redirect, no flush, no misalign pulse. This prevents a bubble from redirecting.
- Stall, no redirect: pc, if_id_instr, if_id_pc_plus4 and if_id_valid all hold. imem_addr is unchanged.
- Normal cycle: pc <= pc+4; if_id_instr <= imem_rdata; if_id_pc_plus4 <= pc+4; if_id_valid <= 1.
- First cycle after reset release: fetches RESET_PC, and if_id_valid becomes 1 at the following edge.
- Multiple redirect sources asserted together: only the highest-priority one is used. jr_misaligned pulses only if JR is the one chosen.

Test Plan:
1. Reset then 4 free-running cycles, imem_rdata=addr-tagged -> imem_addr 0,4,8,C. if_id_pc_plus4 4,8,C. if_id_valid 0 then 1 from second edge.
2. stall=1 for 3 cycles at pc=0x10 -> imem_addr stays 0x10. IF/ID unchanged. Resumes at 0x14 after release.
3. jr_control=1, jr_target=0x0000_0203, if_id_valid=1 -> flush=1 that cycle. Next pc=0x200. if_id_valid=0, if_id_instr=NOP_INSTR. jr_misaligned=1 for one cycle.
4. jump=1, branch_taken=1, if_id_pc_plus4=0x4000_0010, jump_index=26'h000_0040 -> next pc=0x4000_0100; branch ignored. Same with stall=1 -> redirect still taken.
5. branch_taken=1 while if_id_valid=0 (bubble after flush) -> no redirect, flush=0. pc advances by 4.
6. Run sequentially to pc=0xFFFF_FFFC -> next pc=0x0000_0000. Assert reset_n=0 mid-cycle during a redirect -> outputs return to reset values immediately, without waiting for clk.
